// File: rtl/id_ex_operand_stage_pkg.sv
// Constants shared by the decode stage and the ID/EX segment register.
package id_ex_operand_stage_pkg;

    localparam int unsigned WIDTH_DEF   = 32;
    localparam int unsigned DEPTH_B_DEF = 5;
    localparam int unsigned CTRL_W_DEF  = 16;
    localparam int unsigned CNT_W_DEF   = 32;

    // Architectural zero register, never a real producer
    localparam int unsigned X0_IDX = 0;

    // Control bundle carried by a bubble
    localparam logic [CTRL_W_DEF-1:0] CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_operand_stage_operand_bypass.sv
// Priority bypass mux for one source operand: x0, then EX, MEM, WB, register file.
module operand_bypass
    import id_ex_operand_stage_pkg::*;
#(
    parameter int unsigned WIDTH   = WIDTH_DEF,
    parameter int unsigned DEPTH_B = DEPTH_B_DEF
) (
    input  logic [DEPTH_B-1:0] idx,
    input  logic [WIDTH-1:0]   rf_data,
    input  logic               ex_en,
    input  logic [DEPTH_B-1:0] ex_rd,
    input  logic [WIDTH-1:0]   ex_data,
    input  logic               mem_en,
    input  logic [DEPTH_B-1:0] mem_rd,
    input  logic [WIDTH-1:0]   mem_data,
    input  logic               wb_en,
    input  logic [DEPTH_B-1:0] wb_rd,
    input  logic [WIDTH-1:0]   wb_data,
    output logic [WIDTH-1:0]   operand_c
);

    always_comb begin
        operand_c = rf_data;
        if (idx == DEPTH_B'(X0_IDX)) begin
            operand_c = '0;
        end else if (ex_en && (ex_rd == idx)) begin
            operand_c = ex_data;
        end else if (mem_en && (mem_rd == idx)) begin
            operand_c = mem_data;
        end else if (wb_en && (wb_rd == idx)) begin
            // WB writes the register file on the same edge, so rf_data is stale here
            operand_c = wb_data;
        end
    end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX boundary: operand bypass, load-use hazard detection, pipeline register, perf counters.
module id_ex_operand_stage
    import id_ex_operand_stage_pkg::*;
#(
    parameter int unsigned WIDTH   = WIDTH_DEF,
    parameter int unsigned DEPTH_B = DEPTH_B_DEF,
    parameter int unsigned CTRL_W  = CTRL_W_DEF,
    parameter int unsigned CNT_W   = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               id_valid,
    input  logic [WIDTH-1:0]   id_pc,
    input  logic [WIDTH-1:0]   id_imm,
    input  logic [CTRL_W-1:0]  id_ctrl,
    input  logic [DEPTH_B-1:0] id_rs1,
    input  logic [DEPTH_B-1:0] id_rs2,
    input  logic               id_use_rs1,
    input  logic               id_use_rs2,
    input  logic [DEPTH_B-1:0] id_rd,
    input  logic               id_rf_we,
    input  logic               id_mem_re,
    output logic [DEPTH_B-1:0] rf_ra0,
    output logic [DEPTH_B-1:0] rf_ra1,
    input  logic [WIDTH-1:0]   rf_rd0,
    input  logic [WIDTH-1:0]   rf_rd1,
    input  logic [WIDTH-1:0]   ex_fwd_wd,
    input  logic [DEPTH_B-1:0] mem_rd,
    input  logic               mem_rf_we,
    input  logic               mem_mem_re,
    input  logic [WIDTH-1:0]   mem_wd,
    input  logic [DEPTH_B-1:0] wb_rd,
    input  logic               wb_rf_we,
    input  logic [WIDTH-1:0]   wb_wd,
    input  logic               flush,
    output logic               stall_id,
    output logic               ex_valid,
    output logic               ex_rf_we,
    output logic               ex_mem_re,
    output logic [WIDTH-1:0]   ex_pc,
    output logic [WIDTH-1:0]   ex_imm,
    output logic [WIDTH-1:0]   ex_rs1_val,
    output logic [WIDTH-1:0]   ex_rs2_val,
    output logic [DEPTH_B-1:0] ex_rd,
    output logic [CTRL_W-1:0]  ex_ctrl,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   flush_cnt
);

    logic [WIDTH-1:0] rs1_val_c;
    logic [WIDTH-1:0] rs2_val_c;
    logic             ex_fwd_en_c;
    logic             rs1_lu_c;
    logic             rs2_lu_c;
    logic             hz_c;

    assign rf_ra0      = id_rs1;
    assign rf_ra1      = id_rs2;
    assign ex_fwd_en_c = ex_valid && ex_rf_we;

    operand_bypass #(.WIDTH(WIDTH), .DEPTH_B(DEPTH_B)) u_bypass_rs1 (
        .idx      (id_rs1),
        .rf_data  (rf_rd0),
        .ex_en    (ex_fwd_en_c),
        .ex_rd    (ex_rd),
        .ex_data  (ex_fwd_wd),
        .mem_en   (mem_rf_we),
        .mem_rd   (mem_rd),
        .mem_data (mem_wd),
        .wb_en    (wb_rf_we),
        .wb_rd    (wb_rd),
        .wb_data  (wb_wd),
        .operand_c(rs1_val_c)
    );

    operand_bypass #(.WIDTH(WIDTH), .DEPTH_B(DEPTH_B)) u_bypass_rs2 (
        .idx      (id_rs2),
        .rf_data  (rf_rd1),
        .ex_en    (ex_fwd_en_c),
        .ex_rd    (ex_rd),
        .ex_data  (ex_fwd_wd),
        .mem_en   (mem_rf_we),
        .mem_rd   (mem_rd),
        .mem_data (mem_wd),
        .wb_en    (wb_rf_we),
        .wb_rd    (wb_rd),
        .wb_data  (wb_wd),
        .operand_c(rs2_val_c)
    );

    // Load data is only available from WB, so a load in EX or MEM must be waited out
    assign rs1_lu_c = (id_rs1 != DEPTH_B'(X0_IDX)) &&
                      ((ex_valid && ex_mem_re && (ex_rd == id_rs1)) ||
                       (mem_rf_we && mem_mem_re && (mem_rd == id_rs1)));
    assign rs2_lu_c = (id_rs2 != DEPTH_B'(X0_IDX)) &&
                      ((ex_valid && ex_mem_re && (ex_rd == id_rs2)) ||
                       (mem_rf_we && mem_mem_re && (mem_rd == id_rs2)));
    assign hz_c     = id_valid && ((id_use_rs1 && rs1_lu_c) || (id_use_rs2 && rs2_lu_c));
    assign stall_id = hz_c && !flush;

    always_ff @(posedge clk) begin
        if (rst || flush || hz_c) begin
            ex_valid   <= 1'b0;
            ex_rf_we   <= 1'b0;
            ex_mem_re  <= 1'b0;
            ex_pc      <= '0;
            ex_imm     <= '0;
            ex_rs1_val <= '0;
            ex_rs2_val <= '0;
            ex_rd      <= '0;
            ex_ctrl    <= CTRL_W'(CTRL_BUBBLE);
        end else begin
            ex_valid   <= id_valid;
            ex_rf_we   <= id_valid && id_rf_we;
            ex_mem_re  <= id_valid && id_mem_re;
            ex_pc      <= id_pc;
            ex_imm     <= id_imm;
            ex_rs1_val <= rs1_val_c;
            ex_rs2_val <= rs2_val_c;
            ex_rd      <= id_rd;
            ex_ctrl    <= id_ctrl;
        end
    end

    // Saturating performance counters
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_id && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (flush && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage with a per-cycle reference model and literal spot checks.
module tb_id_ex_operand_stage;

    localparam int unsigned W   = 32;
    localparam int unsigned DB  = 5;
    localparam int unsigned CW  = 16;
    localparam int unsigned NW  = 4;
    localparam int          CNT_MAX = (1 << NW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          id_valid;
    logic [W-1:0]  id_pc, id_imm;
    logic [CW-1:0] id_ctrl;
    logic [DB-1:0] id_rs1, id_rs2, id_rd;
    logic          id_use_rs1, id_use_rs2, id_rf_we, id_mem_re;
    logic [DB-1:0] rf_ra0, rf_ra1;
    logic [W-1:0]  rf_rd0, rf_rd1, ex_fwd_wd;
    logic [DB-1:0] mem_rd, wb_rd;
    logic          mem_rf_we, mem_mem_re, wb_rf_we;
    logic [W-1:0]  mem_wd, wb_wd;
    logic          flush;
    logic          stall_id;
    logic          ex_valid, ex_rf_we, ex_mem_re;
    logic [W-1:0]  ex_pc, ex_imm, ex_rs1_val, ex_rs2_val;
    logic [DB-1:0] ex_rd;
    logic [CW-1:0] ex_ctrl;
    logic [NW-1:0] stall_cnt, flush_cnt;

    id_ex_operand_stage #(.WIDTH(W), .DEPTH_B(DB), .CTRL_W(CW), .CNT_W(NW)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_pc(id_pc), .id_imm(id_imm), .id_ctrl(id_ctrl),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rd(id_rd), .id_rf_we(id_rf_we), .id_mem_re(id_mem_re),
        .rf_ra0(rf_ra0), .rf_ra1(rf_ra1), .rf_rd0(rf_rd0), .rf_rd1(rf_rd1),
        .ex_fwd_wd(ex_fwd_wd),
        .mem_rd(mem_rd), .mem_rf_we(mem_rf_we), .mem_mem_re(mem_mem_re), .mem_wd(mem_wd),
        .wb_rd(wb_rd), .wb_rf_we(wb_rf_we), .wb_wd(wb_wd),
        .flush(flush), .stall_id(stall_id),
        .ex_valid(ex_valid), .ex_rf_we(ex_rf_we), .ex_mem_re(ex_mem_re),
        .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val),
        .ex_rd(ex_rd), .ex_ctrl(ex_ctrl), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what the EX latch holds, as an instruction record
    logic          m_valid, m_rf_we, m_mem_re;
    logic [W-1:0]  m_pc, m_imm, m_rs1, m_rs2;
    logic [DB-1:0] m_rd;
    logic [CW-1:0] m_ctrl;
    int            m_stall, m_flush;

    // Newest producer that writes idx supplies the value; x0 is always zero
    function automatic logic [W-1:0] pick(input logic [DB-1:0] idx, input logic [W-1:0] rfv);
        logic          en   [3];
        logic [DB-1:0] rds  [3];
        logic [W-1:0]  vals [3];
        if (idx == 0) return '0;
        en   = '{m_valid && m_rf_we, mem_rf_we, wb_rf_we};
        rds  = '{m_rd, mem_rd, wb_rd};
        vals = '{ex_fwd_wd, mem_wd, wb_wd};
        for (int i = 0; i < 3; i++)
            if (en[i] && rds[i] == idx) return vals[i];
        return rfv;
    endfunction

    // A source is blocked while a load producing it sits in EX or MEM
    function automatic bit load_pending(input logic [DB-1:0] r);
        if (r == 0) return 1'b0;
        return (m_valid && m_mem_re && m_rd == r) || (mem_rf_we && mem_mem_re && mem_rd == r);
    endfunction

    function automatic bit m_hz();
        return id_valid && ((id_use_rs1 && load_pending(id_rs1)) ||
                            (id_use_rs2 && load_pending(id_rs2)));
    endfunction

    always @(posedge clk) begin
        bit hz;
        logic [W-1:0] s1, s2;
        hz = m_hz();
        s1 = pick(id_rs1, rf_rd0);
        s2 = pick(id_rs2, rf_rd1);
        if (rst) begin
            m_stall = 0;
            m_flush = 0;
        end else begin
            if (hz && !flush) m_stall = (m_stall < CNT_MAX) ? m_stall + 1 : CNT_MAX;
            if (flush)        m_flush = (m_flush < CNT_MAX) ? m_flush + 1 : CNT_MAX;
        end
        if (rst || flush || hz) begin
            {m_valid, m_rf_we, m_mem_re} = 3'b000;
            m_pc = '0; m_imm = '0; m_rs1 = '0; m_rs2 = '0; m_rd = '0; m_ctrl = '0;
        end else begin
            m_valid  = id_valid;
            m_rf_we  = id_valid && id_rf_we;
            m_mem_re = id_valid && id_mem_re;
            m_pc = id_pc; m_imm = id_imm; m_rs1 = s1; m_rs2 = s2; m_rd = id_rd; m_ctrl = id_ctrl;
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("m_ex_valid",  32'(ex_valid),   32'(m_valid));
            check("m_ex_rf_we",  32'(ex_rf_we),   32'(m_rf_we));
            check("m_ex_mem_re", 32'(ex_mem_re),  32'(m_mem_re));
            check("m_ex_pc",     ex_pc,           m_pc);
            check("m_ex_imm",    ex_imm,          m_imm);
            check("m_ex_rs1",    ex_rs1_val,      m_rs1);
            check("m_ex_rs2",    ex_rs2_val,      m_rs2);
            check("m_ex_rd",     32'(ex_rd),      32'(m_rd));
            check("m_ex_ctrl",   32'(ex_ctrl),    32'(m_ctrl));
            check("m_stall_cnt", 32'(stall_cnt),  32'(m_stall));
            check("m_flush_cnt", 32'(flush_cnt),  32'(m_flush));
            check("m_stall_id",  32'(stall_id),   32'(m_hz() && !flush));
            check("m_rf_ra0",    32'(rf_ra0),     32'(id_rs1));
            check("m_rf_ra1",    32'(rf_ra1),     32'(id_rs2));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; flush = 1'b0;
        id_valid = 1'b0; id_pc = '0; id_imm = '0; id_ctrl = '0;
        id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        id_rd = '0; id_rf_we = 1'b0; id_mem_re = 1'b0;
        rf_rd0 = '0; rf_rd1 = '0; ex_fwd_wd = '0;
        mem_rd = '0; mem_rf_we = 1'b0; mem_mem_re = 1'b0; mem_wd = '0;
        wb_rd = '0; wb_rf_we = 1'b0; wb_wd = '0;
    endtask

    task automatic put_id(input logic [DB-1:0] rd, input logic we, input logic ld,
                          input logic [DB-1:0] rs1, input logic u1,
                          input logic [DB-1:0] rs2, input logic u2, input logic [W-1:0] pc);
        id_valid = 1'b1; id_rd = rd; id_rf_we = we; id_mem_re = ld;
        id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
        id_pc = pc; id_imm = pc ^ 32'h00FF_0000; id_ctrl = CW'(pc + 32'h7);
    endtask

    initial begin
        idle();
        rst = 1'b1;
        tick();
        chk_en = 1'b1;
        check("rst_ex_valid", 32'(ex_valid), 32'h0);
        check("rst_stall_cnt", 32'(stall_cnt), 32'h0);
        check("rst_stall_id", 32'(stall_id), 32'h0);
        rst = 1'b0;

        // id_valid=0: fields still latched, write enables forced low
        id_pc = 32'h40; id_rd = 5'd4; id_rf_we = 1'b1; id_mem_re = 1'b1;
        tick();
        check("inv_ex_pc", ex_pc, 32'h40);
        check("inv_ex_rf_we", 32'(ex_rf_we), 32'h0);

        // RAW on ALU result from EX
        idle();
        put_id(5'd5, 1'b1, 1'b0, 5'd1, 1'b1, 5'd2, 1'b1, 32'h100);
        tick();
        put_id(5'd6, 1'b1, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 32'h104);
        ex_fwd_wd = 32'h11; rf_rd0 = 32'h0;
        #1 check("raw_stall_id", 32'(stall_id), 32'h0);
        tick();
        check("raw_rs1", ex_rs1_val, 32'h11);

        // Priority EX > MEM > WB on x3
        idle();
        put_id(5'd3, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 32'h200);
        tick();
        put_id(5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 32'h204);
        ex_fwd_wd = 32'd1; rf_rd1 = 32'h99;
        mem_rd = 5'd3; mem_rf_we = 1'b1; mem_wd = 32'd2;
        wb_rd = 5'd3; wb_rf_we = 1'b1; wb_wd = 32'd3;
        tick();
        check("prio_ex", ex_rs2_val, 32'd1);
        tick();
        check("prio_mem", ex_rs2_val, 32'd2);
        mem_rf_we = 1'b0;
        tick();
        check("prio_wb", ex_rs2_val, 32'd3);

        // Load-use: lw x7 then add x8,x7,x7
        idle();
        put_id(5'd7, 1'b1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 32'h300);
        tick();
        put_id(5'd8, 1'b1, 1'b0, 5'd7, 1'b1, 5'd7, 1'b1, 32'h304);
        #1 check("lu_stall_1", 32'(stall_id), 32'h1);
        tick();
        check("lu_bubble_1", 32'(ex_valid), 32'h0);
        mem_rd = 5'd7; mem_rf_we = 1'b1; mem_mem_re = 1'b1;
        #1 check("lu_stall_2", 32'(stall_id), 32'h1);
        tick();
        check("lu_bubble_2", 32'(ex_valid), 32'h0);
        check("lu_stall_cnt", 32'(stall_cnt), 32'd2);
        mem_rf_we = 1'b0; mem_mem_re = 1'b0; mem_rd = '0;
        wb_rd = 5'd7; wb_rf_we = 1'b1; wb_wd = 32'hDEAD;
        #1 check("lu_release", 32'(stall_id), 32'h0);
        tick();
        check("lu_rs1", ex_rs1_val, 32'hDEAD);
        check("lu_rs2", ex_rs2_val, 32'hDEAD);
        check("lu_rd", 32'(ex_rd), 32'd8);

        // x0 never forwards and never stalls
        idle();
        put_id(5'd0, 1'b1, 1'b1, 5'd1, 1'b0, 5'd0, 1'b0, 32'h400);
        tick();
        put_id(5'd9, 1'b1, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 32'h404);
        wb_rd = 5'd0; wb_rf_we = 1'b1; wb_wd = 32'hFFFF; rf_rd0 = 32'h1234;
        #1 check("x0_stall_id", 32'(stall_id), 32'h0);
        tick();
        check("x0_rs1", ex_rs1_val, 32'h0);

        // Flush wins over a simultaneous hazard
        idle();
        put_id(5'd9, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 32'h500);
        tick();
        put_id(5'd10, 1'b1, 1'b0, 5'd9, 1'b1, 5'd0, 1'b0, 32'h504);
        flush = 1'b1;
        #1 check("fl_stall_id", 32'(stall_id), 32'h0);
        tick();
        check("fl_bubble", 32'(ex_valid), 32'h0);
        check("fl_flush_cnt", 32'(flush_cnt), 32'd1);
        check("fl_stall_cnt", 32'(stall_cnt), 32'd2);

        // Long stall saturates the counter, then reset mid-stall clears everything
        idle();
        put_id(5'd11, 1'b1, 1'b0, 5'd10, 1'b1, 5'd0, 1'b0, 32'h600);
        mem_rd = 5'd10; mem_rf_we = 1'b1; mem_mem_re = 1'b1;
        for (int i = 0; i < 16; i++) tick();
        check("sat_stall_cnt", 32'(stall_cnt), 32'(CNT_MAX));
        tick();
        check("sat_hold", 32'(stall_cnt), 32'(CNT_MAX));
        mem_rf_we = 1'b0; mem_mem_re = 1'b0;
        tick();
        check("pre_rst_valid", 32'(ex_valid), 32'h1);
        mem_rf_we = 1'b1; mem_mem_re = 1'b1;
        rst = 1'b1;
        tick();
        check("rst2_ex_valid", 32'(ex_valid), 32'h0);
        check("rst2_ex_pc", ex_pc, 32'h0);
        check("rst2_stall_cnt", 32'(stall_cnt), 32'h0);
        check("rst2_flush_cnt", 32'(flush_cnt), 32'h0);
        idle();
        #1 check("rst2_stall_id", 32'(stall_id), 32'h0);
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
